// File: rtl/cgia_pkg.sv
// Shared definitions for the pixel shifter control path: depth encodings,
// sequencer state type and the pixels-per-word helper.
package cgia_pkg;

  // Depth encodings as presented on mode_i.
  localparam logic [1:0] BPP1 = 2'd0;
  localparam logic [1:0] BPP2 = 2'd1;
  localparam logic [1:0] BPP4 = 2'd2;
  localparam logic [1:0] BPP8 = 2'd3;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StPrime,
    StRun
  } seq_state_e;

  // Pixels per word minus one: the reload value of the pixel counter.
  function automatic logic [3:0] ppw_minus1(input logic [1:0] mode);
    logic [3:0] r;
    case (mode)
      BPP1:    r = 4'd15;
      BPP2:    r = 4'd7;
      BPP4:    r = 4'd3;
      default: r = 4'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_word_buffer.sv
// One-entry hold register between the prefetch FIFO and the shifter load path.
// Flush beats push, push beats pop: a word popped from the FIFO in the same dot
// that the current hold contents are loaded replaces them at the edge.
module shift_word_buffer
  import cgia_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  output logic        full_o
);

  logic        full_q, full_d;
  logic [15:0] data_q, data_d;

  // Next-state of the hold slot.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (push_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  // Hold slot registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= 16'h0000;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/shift_sequencer.sv
// Upstream control stage of the pixel shifter: pulls words from the line
// prefetch FIFO through a one-deep hold buffer and drives load / depth strobes.
// Optional build macro SHIFT_SEQ_UNDERRUN_EN adds the underrun_o flag and
// underrun_cnt_o counter ports.
module shift_sequencer
  import cgia_pkg::*;
#(
  parameter int unsigned WORD_CNT_W = 8
) (
  input  logic                  dotclk_i,
  input  logic                  reset_i,
  input  logic                  line_start_i,
  input  logic [1:0]            mode_i,
  input  logic [WORD_CNT_W-1:0] words_i,
  input  logic [15:0]           fifo_dat_i,
  input  logic                  fifo_valid_i,
  output logic                  fifo_pop_o,
  output logic [15:0]           dat_o,
  output logic                  load_o,
  output logic                  shift1_o,
  output logic                  shift2_o,
  output logic                  shift4_o,
  output logic                  shift8_o,
  output logic                  busy_o
`ifdef SHIFT_SEQ_UNDERRUN_EN
  ,
  output logic                  underrun_o,
  output logic [7:0]            underrun_cnt_o
`endif
);

  seq_state_e            state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [WORD_CNT_W-1:0] words_left_q, words_left_d;
  logic [3:0]            pix_cnt_q, pix_cnt_d;

  logic        buf_push, buf_pop, buf_flush, buf_full;
  logic [15:0] buf_data;

  shift_word_buffer u_hold (
    .clk_i   (dotclk_i),
    .rst_i   (reset_i),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .flush_i (buf_flush),
    .data_i  (fifo_dat_i),
    .data_o  (buf_data),
    .full_o  (buf_full)
  );

  // FSM next-state, counters, FIFO pop and load decisions.
  // words_left counts words not yet loaded; a refill is allowed only while that
  // count (after this dot's load) is non-zero and the hold slot is empty, so
  // pops per span never exceed the latched word count.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    words_left_d = words_left_q;
    pix_cnt_d    = pix_cnt_q;
    load_o       = 1'b0;
    fifo_pop_o   = 1'b0;
    buf_push     = 1'b0;
    buf_pop      = 1'b0;
    buf_flush    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (line_start_i && (words_i != '0)) begin
          state_d      = StFetch;
          mode_d       = mode_i;
          words_left_d = words_i;
          pix_cnt_d    = '0;
        end
      end
      StFetch: begin
        if (fifo_valid_i) begin
          fifo_pop_o = 1'b1;
          buf_push   = 1'b1;
          state_d    = StPrime;
        end
      end
      StPrime: begin
        load_o       = 1'b1;
        buf_pop      = 1'b1;
        words_left_d = words_left_q - WORD_CNT_W'(1);
        pix_cnt_d    = ppw_minus1(mode_q);
        state_d      = StRun;
      end
      StRun: begin
        if (pix_cnt_q == 4'd0) begin
          if (words_left_q != '0) begin
            load_o       = 1'b1;
            buf_pop      = 1'b1;
            words_left_d = words_left_q - WORD_CNT_W'(1);
            pix_cnt_d    = ppw_minus1(mode_q);
          end else begin
            state_d = StIdle;
          end
        end else begin
          pix_cnt_d = pix_cnt_q - 4'd1;
        end
        if (!buf_full && fifo_valid_i && (words_left_d != '0)) begin
          fifo_pop_o = 1'b1;
          buf_push   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Restart while busy: drop the hold word and any load/pop of this dot so
    // nothing from the abandoned span reaches the shifter. A zero-length
    // restart simply ends the span.
    if (line_start_i && (state_q != StIdle)) begin
      load_o     = 1'b0;
      fifo_pop_o = 1'b0;
      buf_push   = 1'b0;
      buf_pop    = 1'b0;
      buf_flush  = 1'b1;
      pix_cnt_d  = '0;
      if (words_i != '0) begin
        state_d      = StFetch;
        mode_d       = mode_i;
        words_left_d = words_i;
      end else begin
        state_d      = StIdle;
        words_left_d = '0;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge dotclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      mode_q       <= BPP1;
      words_left_q <= '0;
      pix_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      words_left_q <= words_left_d;
      pix_cnt_q    <= pix_cnt_d;
    end
  end

  // Shifter data and depth strobes; an empty hold at load time shifts in zeros.
  always_comb begin
    dat_o    = (load_o && buf_full) ? buf_data : 16'h0000;
    shift1_o = (state_q == StRun) && (mode_q == BPP1);
    shift2_o = (state_q == StRun) && (mode_q == BPP2);
    shift4_o = (state_q == StRun) && (mode_q == BPP4);
    shift8_o = (state_q == StRun) && (mode_q == BPP8);
    busy_o   = (state_q != StIdle);
  end

`ifdef SHIFT_SEQ_UNDERRUN_EN
  logic       underrun_evt;
  logic       underrun_q, underrun_d;
  logic [7:0] ur_cnt_q, ur_cnt_d;

  assign underrun_evt = load_o & ~buf_full;

  // Sticky underrun flag and saturating count, cleared on every line start.
  always_comb begin
    underrun_d = underrun_q;
    ur_cnt_d   = ur_cnt_q;
    if (line_start_i) begin
      underrun_d = 1'b0;
      ur_cnt_d   = 8'd0;
    end else if (underrun_evt) begin
      underrun_d = 1'b1;
      if (ur_cnt_q != 8'hFF) begin
        ur_cnt_d = ur_cnt_q + 8'd1;
      end
    end
  end

  // Underrun statistics registers.
  always_ff @(posedge dotclk_i or posedge reset_i) begin
    if (reset_i) begin
      underrun_q <= 1'b0;
      ur_cnt_q   <= 8'd0;
    end else begin
      underrun_q <= underrun_d;
      ur_cnt_q   <= ur_cnt_d;
    end
  end

  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ur_cnt_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer. Expected loads are queued when a span
// is issued; a negedge monitor pops them whenever load_o is seen and also
// checks strobes/busy against per-dot expectations from a span-level model.
module tb_shift_sequencer;

  localparam int MaxDot = 8192;

  logic        dotclk = 1'b0;
  logic        reset_i;
  logic        line_start_i;
  logic [1:0]  mode_i;
  logic [7:0]  words_i;
  logic [15:0] fifo_dat_i;
  logic        fifo_valid_i;
  logic        fifo_pop_o;
  logic [15:0] dat_o;
  logic        load_o;
  logic        shift1_o, shift2_o, shift4_o, shift8_o;
  logic        busy_o;
`ifdef SHIFT_SEQ_UNDERRUN_EN
  logic        underrun_o;
  logic [7:0]  underrun_cnt_o;
`endif

  shift_sequencer #(.WORD_CNT_W(8)) dut (
    .dotclk_i     (dotclk),
    .reset_i      (reset_i),
    .line_start_i (line_start_i),
    .mode_i       (mode_i),
    .words_i      (words_i),
    .fifo_dat_i   (fifo_dat_i),
    .fifo_valid_i (fifo_valid_i),
    .fifo_pop_o   (fifo_pop_o),
    .dat_o        (dat_o),
    .load_o       (load_o),
    .shift1_o     (shift1_o),
    .shift2_o     (shift2_o),
    .shift4_o     (shift4_o),
    .shift8_o     (shift8_o),
    .busy_o       (busy_o)
`ifdef SHIFT_SEQ_UNDERRUN_EN
    ,
    .underrun_o     (underrun_o),
    .underrun_cnt_o (underrun_cnt_o)
`endif
  );

  always #5 dotclk = ~dotclk;

  typedef struct {
    int          dot;
    logic [15:0] dat;
  } load_t;

  load_t       load_q[$];
  logic [15:0] fifo_q[$];
  logic [15:0] seed_q[$];
  bit   [3:0]  exp_strb [MaxDot];
  bit          exp_busy [MaxDot];

  int dot = 0;
  int fifo_from = 0;
  int cur_end = 0;
  int exp_pops = 0;
  int exp_ur = 0;
  int span_pops = 0;
  int n_checks = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at dot %0d", name, act, exp, dot);
  endfunction

  task automatic drive_fifo();
    fifo_valid_i = (fifo_q.size() > 0) && (dot >= fifo_from);
    fifo_dat_i   = fifo_valid_i ? fifo_q[0] : 16'($urandom);
  endtask

  // Advance one dot; the environment FIFO reacts to pops seen mid-dot.
  task automatic tick();
    logic pop_seen;
    @(negedge dotclk);
    pop_seen = fifo_pop_o;
    @(posedge dotclk);
    #1;
    if (pop_seen) begin
      span_pops++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    dot++;
    drive_fifo();
  endtask

  task automatic clear_exp(input int from);
    for (int d = from; d < from + 400 && d < MaxDot; d++) begin
      exp_busy[d] = 1'b0;
      exp_strb[d] = 4'b0000;
    end
  endtask

  // Issue a span: md depth, wd words, m words available in the FIFO from
  // dot S+vrel (vrel >= 1). First load lands one dot after the first pop,
  // later loads every ppw dots; words beyond the supply load as zero.
  task automatic start_span(input int md, input int wd, input int m, input int vrel);
    int s, ppw, l0, have;
    s = dot;
    ppw = 16 >> md;
    while (load_q.size() > 0 && load_q[$].dot >= s) void'(load_q.pop_back());
    fifo_q.delete();
    for (int k = 0; k < m; k++) begin
      fifo_q.push_back((k < seed_q.size()) ? seed_q[k] : 16'($urandom));
    end
    seed_q.delete();
    fifo_from = s + vrel;
    l0 = s + vrel + 1;
    cur_end = l0 + wd * ppw;
    for (int k = 0; k < wd; k++) begin
      load_q.push_back('{dot: l0 + k * ppw, dat: (k < m) ? fifo_q[k] : 16'h0000});
    end
    clear_exp(s + 1);
    for (int d = s + 1; d <= cur_end; d++) begin
      exp_busy[d] = 1'b1;
      if (d > l0) exp_strb[d] = 4'(1 << md);
    end
    have = (m < wd) ? m : wd;
    exp_pops = have;
    exp_ur = wd - have;
    span_pops = 0;
    mode_i = 2'(md);
    words_i = 8'(wd);
    line_start_i = 1'b1;
    drive_fifo();
    tick();
    line_start_i = 1'b0;
    mode_i = 2'($urandom);
    words_i = 8'($urandom);
  endtask

  task automatic finish_span();
    while (dot <= cur_end) tick();
    tick();
    check("span_pops", 32'(span_pops), 32'(exp_pops));
`ifdef SHIFT_SEQ_UNDERRUN_EN
    check("underrun_flag", 32'(underrun_o), 32'(exp_ur != 0));
    check("underrun_cnt", 32'(underrun_cnt_o), 32'(exp_ur));
`endif
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({fifo_pop_o, load_o, dat_o, shift1_o, shift2_o, shift4_o, shift8_o, busy_o});
  endfunction

  // Monitor: compares DUT outputs against the scoreboard once per dot.
  always @(negedge dotclk) begin
    if (mon_en && dot < MaxDot) begin
      check("busy", 32'(busy_o), 32'(exp_busy[dot]));
      check("strobes", 32'({shift8_o, shift4_o, shift2_o, shift1_o}), 32'(exp_strb[dot]));
      if (fifo_pop_o) check("pop_needs_valid", 32'(fifo_valid_i), 32'd1);
      while (load_q.size() > 0 && load_q[0].dot < dot) begin
        check("load_missing", 32'(dot), 32'(load_q[0].dot));
        void'(load_q.pop_front());
      end
      if (load_o) begin
        if (load_q.size() == 0) begin
          check("load_unexpected", 32'(load_o), 32'd0);
        end else begin
          check("load_dot", 32'(dot), 32'(load_q[0].dot));
          check("load_dat", 32'(dat_o), 32'(load_q[0].dat));
          void'(load_q.pop_front());
        end
      end else begin
        check("dat_idle", 32'(dat_o), 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at dot %0d", dot);
    $fatal(1, "watchdog");
  end

  initial begin
    int md, wd, m, vr, n;
    reset_i = 1'b1;
    line_start_i = 1'b0;
    mode_i = 2'd0;
    words_i = 8'd0;
    fifo_valid_i = 1'b0;
    fifo_dat_i = 16'h0000;
    #1;
    check("reset_outputs", all_outputs(), 32'd0);
`ifdef SHIFT_SEQ_UNDERRUN_EN
    check("reset_underrun", 32'({underrun_o, underrun_cnt_o}), 32'd0);
`endif
    @(posedge dotclk);
    @(posedge dotclk);
    #1;
    reset_i = 1'b0;
    dot = 0;
    drive_fifo();
    mon_en = 1'b1;
    repeat (3) tick();

    // 8bpp, two words, FIFO holds more than needed.
    seed_q.push_back(16'hA1B2);
    seed_q.push_back(16'hC3D4);
    start_span(3, 2, 4, 1);
    finish_span();

    // 1bpp single word.
    start_span(0, 1, 2, 1);
    finish_span();

    // 2bpp, FIFO not valid until dot 10.
    start_span(1, 3, 3, 10);
    finish_span();

    // 4bpp, FIFO runs dry after two words.
    start_span(2, 4, 2, 1);
    finish_span();

    // Zero-length line start is ignored.
    clear_exp(dot + 1);
    words_i = 8'd0;
    line_start_i = 1'b1;
    tick();
    line_start_i = 1'b0;
    repeat (4) tick();

    // Restart mid-RUN while the hold slot is full.
    start_span(1, 3, 3, 1);
    repeat (5) tick();
    start_span(0, 1, 1, 1);
    finish_span();

    // Asynchronous reset between edges mid-span.
    start_span(2, 4, 4, 1);
    repeat (6) tick();
    #1;
    reset_i = 1'b1;
    #1;
    check("async_reset_outputs", all_outputs(), 32'd0);
    clear_exp(dot);
    load_q.delete();
    fifo_q.delete();
    drive_fifo();
    tick();
    #2;
    reset_i = 1'b0;
    repeat (8) tick();
`ifdef SHIFT_SEQ_UNDERRUN_EN
    check("post_reset_underrun", 32'({underrun_o, underrun_cnt_o}), 32'd0);
`endif

    // Randomized spans, some restarted early.
    for (int it = 0; it < 16; it++) begin
      md = $urandom_range(0, 3);
      wd = $urandom_range(1, 6);
      m  = $urandom_range(1, wd + 1);
      vr = $urandom_range(1, 4);
      start_span(md, wd, m, vr);
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, cur_end - dot);
        repeat (n) tick();
      end else begin
        finish_span();
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    finish_span();
    repeat (3) tick();
    check("loads_drained", 32'(load_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
